// File: rtl/conv_result_reader.sv
// Read-side sequencer for the convolution result bank: snapshots every result
// word on start, then streams them out lowest index first over valid/ready.
module conv_result_reader #(
  parameter int NUM_RESULTS = 4,
  parameter int WIDTH       = 8,
  parameter int IDX_W       = 2
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         start,
  input  logic [NUM_RESULTS*WIDTH-1:0] res_flat,
  output logic [WIDTH-1:0]             out_data,
  output logic [IDX_W-1:0]             out_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RESULTS - 1);

  state_t                       r_state;
  state_t                       w_stateNext;
  logic [NUM_RESULTS*WIDTH-1:0] r_shadow;
  logic [NUM_RESULTS*WIDTH-1:0] w_shadowNext;
  logic [WIDTH-1:0]             r_data;
  logic [WIDTH-1:0]             w_dataNext;
  logic [IDX_W-1:0]             r_idx;
  logic [IDX_W-1:0]             w_idxNext;
  logic [IDX_W-1:0]             w_idxInc;
  logic                         r_valid;
  logic                         w_validNext;
  logic                         r_busy;
  logic                         w_busyNext;
  logic                         r_done;
  logic                         w_doneNext;
  logic                         w_transfer;

  assign w_idxInc   = r_idx + 1'b1;
  assign w_transfer = r_valid & out_ready;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_data   <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_shadow <= w_shadowNext;
      r_data   <= w_dataNext;
      r_idx    <= w_idxNext;
      r_valid  <= w_validNext;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
    end
  end

  // Word 0 comes straight from res_flat on the capture edge, since the shadow
  // bank only holds it from the following cycle onwards.
  always_comb begin
    w_stateNext  = r_state;
    w_shadowNext = r_shadow;
    w_dataNext   = r_data;
    w_idxNext    = r_idx;
    w_validNext  = r_valid;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_shadowNext = res_flat;
          w_dataNext   = res_flat[WIDTH-1:0];
          w_idxNext    = '0;
          w_validNext  = 1'b1;
          w_busyNext   = 1'b1;
          w_stateNext  = SEND;
        end
      end
      SEND: begin
        if (w_transfer) begin
          if (r_idx == LAST_IDX) begin
            w_validNext = 1'b0;
            w_busyNext  = 1'b0;
            w_doneNext  = 1'b1;
            w_stateNext = DONE;
          end else begin
            w_idxNext  = w_idxInc;
            w_dataNext = r_shadow[w_idxInc*WIDTH +: WIDTH];
          end
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
        w_validNext = 1'b0;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_valid = r_valid;
  assign out_last  = r_valid & (r_idx == LAST_IDX);
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_conv_result_reader.sv
// Bench for conv_result_reader: directed scenarios plus randomized readouts,
// checked each cycle against a transaction-level reference model.
module tb_conv_result_reader;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           clr;
  logic           start;
  logic           outReady;
  logic [N*W-1:0] resFlat;
  logic [W-1:0]   outData;
  logic [IW-1:0]  outIdx;
  logic           outValid;
  logic           outLast;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  // Reference model: readout phase (0 idle, 1 sending, 2 done), position and
  // the words captured at start.
  int         mMode = 0;
  int         mPos  = 0;
  logic [W-1:0] mSnap[N];
  int         dutDones = 0;
  logic [W-1:0] expQ[$];
  logic [W-1:0] gotQ[$];

  conv_result_reader #(
    .NUM_RESULTS(N),
    .WIDTH(W),
    .IDX_W(IW)
  ) dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .res_flat(resFlat),
    .out_data(outData),
    .out_idx(outIdx),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_last(outLast),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    start    = s;
    outReady = r;
  endtask

  task automatic checkOutput();
    logic v;
    v = (mMode == 1);
    checkVal("out_valid", {31'b0, outValid}, {31'b0, v});
    checkVal("busy", {31'b0, busy}, {31'b0, v});
    checkVal("done", {31'b0, done}, {31'b0, mMode == 2});
    checkVal("out_last", {31'b0, outLast}, {31'b0, v && (mPos == N - 1)});
    if (v) begin
      checkVal("out_data", {24'b0, outData}, {24'b0, mSnap[mPos]});
      checkVal("out_idx", {30'b0, outIdx}, mPos);
    end
    if (!clr) begin
      checkVal("reset_data", {24'b0, outData}, 32'h0);
      checkVal("reset_idx", {30'b0, outIdx}, 32'h0);
    end
  endtask

  // Advance one clock: log any transfer seen before the edge, advance the
  // model with the same inputs, then compare just after the edge.
  task automatic step();
    if (outValid && outReady) gotQ.push_back(outData);
    if (!clr) begin
      mMode = 0;
      mPos  = 0;
      foreach (mSnap[k]) mSnap[k] = '0;
    end else begin
      case (mMode)
        0: if (start) begin
          for (int k = 0; k < N; k++) mSnap[k] = resFlat[k*W +: W];
          mPos  = 0;
          mMode = 1;
        end
        1: if (outReady) begin
          expQ.push_back(mSnap[mPos]);
          if (mPos == N - 1) mMode = 2;
          else mPos++;
        end
        default: mMode = 0;
      endcase
    end
    @(posedge clk);
    #1;
    if (done) dutDones++;
    checkOutput();
  endtask

  task automatic compareStreams(input string tag);
    checkVal({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
      checkVal(tag, {24'b0, gotQ[i]}, {24'b0, expQ[i]});
    gotQ.delete();
    expQ.delete();
  endtask

  // One readout from a start pulse until done, then the DONE cycle itself.
  task automatic runReadout(input bit holdStart, input bit noiseStart, input int stallAt,
                            input int stallLen, input bit randReady, input bit changeRes,
                            output int n, output int busyCyc);
    int stallCnt;
    bit r;
    n        = 0;
    busyCyc  = 0;
    stallCnt = 0;
    applyStimulus(1'b1, 1'b1);
    while (n < 60) begin
      step();
      n++;
      if (busy) busyCyc++;
      if (done) break;
      if (changeRes && n == 1) resFlat = '1;
      r = 1'b1;
      if (randReady) r = 1'($urandom_range(0, 1));
      else if (mMode == 1 && mPos == stallAt && stallCnt < stallLen) begin
        r = 1'b0;
        stallCnt++;
      end
      applyStimulus(holdStart | noiseStart, r);
    end
    if (!done) checkVal("done_timeout", 32'h0, 32'h1);
    applyStimulus(holdStart | noiseStart, 1'b1);
    step();
  endtask

  initial begin
    int n;
    int bc;
    int d0;
    int gap;
    clr      = 1'b1;
    resFlat  = 32'h44332211;
    applyStimulus(1'b1, 1'b1);
    #2 clr = 1'b0;
    repeat (3) step();
    clr = 1'b1;

    $display("[TB] readout after reset release");
    runReadout(1'b0, 1'b0, -1, 0, 1'b0, 1'b0, n, bc);
    compareStreams("post_reset_stream");

    $display("[TB] full-rate readout");
    runReadout(1'b0, 1'b0, -1, 0, 1'b0, 1'b0, n, bc);
    checkVal("start_to_done", n, N + 1);
    checkVal("busy_cycles", bc, N);
    compareStreams("full_rate_stream");

    $display("[TB] backpressure on word 1");
    runReadout(1'b0, 1'b0, 1, 3, 1'b0, 1'b0, n, bc);
    checkVal("bp_start_to_done", n, N + 4);
    compareStreams("backpressure_stream");

    $display("[TB] snapshot isolation");
    runReadout(1'b0, 1'b0, -1, 0, 1'b0, 1'b1, n, bc);
    checkVal("snapshot_count", gotQ.size(), N);
    for (int k = 0; k < N && k < gotQ.size(); k++)
      checkVal("snapshot_word", {24'b0, gotQ[k]}, 32'h11 * (k + 1));
    compareStreams("snapshot_stream");
    resFlat = 32'h44332211;

    $display("[TB] start while busy");
    d0 = dutDones;
    runReadout(1'b0, 1'b1, -1, 0, 1'b0, 1'b0, n, bc);
    applyStimulus(1'b0, 1'b1);
    repeat (2) step();
    checkVal("single_done", dutDones - d0, 1);
    compareStreams("start_busy_stream");

    $display("[TB] start held high");
    runReadout(1'b1, 1'b0, -1, 0, 1'b0, 1'b0, n, bc);
    gap = 1;
    while (!outValid && gap < 10) begin
      step();
      gap++;
    end
    checkVal("done_to_valid_gap", gap, 2);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 40 && mMode != 0; i++) step();
    step();
    compareStreams("held_start_stream");

    $display("[TB] randomized readouts");
    for (int it = 0; it < 8; it++) begin
      resFlat = $urandom();
      runReadout(1'b0, 1'($urandom_range(0, 1)), -1, 0, 1'b1, 1'b0, n, bc);
      applyStimulus(1'b0, 1'b1);
      step();
      compareStreams("random_stream");
    end

    $display("[TB] reset mid-readout");
    resFlat = 32'h44332211;
    d0 = dutDones;
    applyStimulus(1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 10 && mPos != 2; i++) step();
    #2 clr = 1'b0;
    #1;
    checkVal("abort_valid", {31'b0, outValid}, 32'h0);
    checkVal("abort_busy", {31'b0, busy}, 32'h0);
    checkVal("abort_done", {31'b0, done}, 32'h0);
    checkVal("abort_last", {31'b0, outLast}, 32'h0);
    repeat (2) step();
    clr = 1'b1;
    checkVal("abort_no_done", dutDones - d0, 0);
    compareStreams("abort_stream");
    runReadout(1'b0, 1'b0, -1, 0, 1'b0, 1'b0, n, bc);
    compareStreams("after_abort_stream");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
